// File: rtl/apple_spawner.sv
// apple_spawner: chooses a free grid cell for the next apple. A free-running
// LFSR proposes random candidates. Each in-range candidate is checked against
// the snake via a one-cycle occupancy query. After MAX_TRIES rejected
// candidates, the search falls back to a row-major scan of every cell, which
// ends either on a free cell or with the board reported as full.
module apple_spawner #(
    parameter int          GRID_COLS = 20,
    parameter int          GRID_ROWS = 15,
    parameter int          CELL_SIZE = 32,
    parameter int          MAX_TRIES = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startGame,
    input  logic        apple_eaten,
    input  logic        occupied,
    output logic        query_valid,
    output logic [4:0]  query_col,
    output logic [3:0]  query_row,
    output logic [31:0] topLeft_x,
    output logic [31:0] topLeft_y,
    output logic        apple_valid,
    output logic        board_full,
    output logic [15:0] spawn_count
);

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [4:0]       LAST_COL = 5'(GRID_COLS - 1);
    localparam logic [3:0]       LAST_ROW = 4'(GRID_ROWS - 1);
    localparam logic [31:0]      CELL_PX  = 32'(CELL_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        QUERY,
        WAIT,
        SCAN_Q,
        SCAN_W,
        PLACED,
        FULL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      lfsr;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_nxt;
    logic [4:0]       col_nxt;
    logic [3:0]       row_nxt;
    logic [4:0]       cand_col;
    logic [3:0]       cand_row;
    logic             cand_ok;
    logic             reject;
    logic             place;

    // The random candidate is taken straight from the current LFSR value.
    assign cand_col = lfsr[4:0];
    assign cand_row = lfsr[11:8];
    assign cand_ok  = (cand_col <= LAST_COL) && (cand_row <= LAST_ROW);

    // Status outputs are pure functions of the state.
    assign query_valid = (state == QUERY) || (state == SCAN_Q);
    assign apple_valid = (state == PLACED);
    assign board_full  = (state == FULL);

    // Fibonacci LFSR, taps 16,14,13,11; it runs every cycle outside reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. query_col/query_row double as the latched candidate
    // and the scan index. Each rejection spends one try; the rejection that
    // uses up the last try jumps directly to the scan at cell (0,0).
    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        col_nxt   = query_col;
        row_nxt   = query_row;
        reject    = 1'b0;
        place     = 1'b0;
        if (startGame) begin
            state_nxt = PICK;
            tries_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                end
                PICK: begin
                    if (cand_ok) begin
                        col_nxt   = cand_col;
                        row_nxt   = cand_row;
                        state_nxt = QUERY;
                    end else begin
                        reject = 1'b1;
                    end
                end
                QUERY: begin
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (!occupied) begin
                        state_nxt = PLACED;
                        place     = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                SCAN_Q: begin
                    state_nxt = SCAN_W;
                end
                SCAN_W: begin
                    if (!occupied) begin
                        state_nxt = PLACED;
                        place     = 1'b1;
                    end else if ((query_col == LAST_COL) && (query_row == LAST_ROW)) begin
                        state_nxt = FULL;
                    end else begin
                        state_nxt = SCAN_Q;
                        if (query_col == LAST_COL) begin
                            col_nxt = '0;
                            row_nxt = query_row + 4'd1;
                        end else begin
                            col_nxt = query_col + 5'd1;
                        end
                    end
                end
                PLACED: begin
                    if (apple_eaten) begin
                        state_nxt = PICK;
                        tries_nxt = '0;
                    end
                end
                FULL: begin
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            if (reject) begin
                if (tries == TRY_LAST) begin
                    state_nxt = SCAN_Q;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end else begin
                    state_nxt = PICK;
                    tries_nxt = tries + TRY_W'(1);
                end
            end
        end
    end

    // Try counter and query/candidate registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tries     <= '0;
            query_col <= '0;
            query_row <= '0;
        end else begin
            tries     <= tries_nxt;
            query_col <= col_nxt;
            query_row <= row_nxt;
        end
    end

    // Placement: pixel position and spawn counter update when PLACED is entered.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            topLeft_x   <= '0;
            topLeft_y   <= '0;
            spawn_count <= '0;
        end else if (startGame) begin
            spawn_count <= '0;
        end else if (place) begin
            topLeft_x   <= {27'd0, query_col} * CELL_PX;
            topLeft_y   <= {28'd0, query_row} * CELL_PX;
            spawn_count <= spawn_count + 16'd1;
        end
    end

endmodule

// File: doc/apple_spawner.md
APPLE_SPAWNER -- requirements
Module: apple_spawner

Interface
REQ-001 SHALL have parameter GRID_COLS, default 20, meaning number of grid columns.
REQ-002 SHALL have parameter GRID_ROWS, default 15, meaning number of grid rows.
REQ-003 SHALL have parameter CELL_SIZE, default 32, meaning cell edge in pixels.
REQ-004 SHALL have parameter MAX_TRIES, default 16, meaning random attempts before falling back to a scan.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning LFSR reset value; it shall be nonzero.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 resetN  input  1  asynchronous, active-low reset.
REQ-008 startGame  input  1  one-cycle pulse; clears the block and starts the first spawn.
REQ-009 apple_eaten  input  1  one-cycle pulse; requests a new apple.
REQ-010 occupied  input  1  snake occupancy of the queried cell, valid exactly 1 cycle after query_valid.
REQ-011 query_valid  output  1  one-cycle occupancy query strobe.
REQ-012 query_col  output  5  queried column; stable while query_valid=1.
REQ-013 query_row  output  4  queried row; stable while query_valid=1.
REQ-014 topLeft_x  output  32  apple pixel x, equal to col*CELL_SIZE.
REQ-015 topLeft_y  output  32  apple pixel y, equal to row*CELL_SIZE.
REQ-016 apple_valid  output  1  apple placed and drawable.
REQ-017 board_full  output  1  no free cell was found.
REQ-018 spawn_count  output  16  number of successful placements since start, wrapping.

Function
REQ-019 SHALL run a 16-bit Fibonacci LFSR with taps 16,14,13,11 that advances every cycle outside reset.
REQ-020 SHALL implement states IDLE, PICK, QUERY, WAIT, SCAN_Q, SCAN_W, PLACED, FULL.
REQ-021 IDLE: outputs hold; a startGame pulse moves to PICK with tries=0.
REQ-022 PICK: candidate col=lfsr[4:0], row=lfsr[11:8].
- If col>=GRID_COLS or row>=GRID_ROWS, tries increments and the state stays PICK.
- Otherwise the candidate is latched and the state moves to QUERY.
REQ-023 QUERY: query_valid=1 for exactly one cycle with the latched candidate, then WAIT.
REQ-024 WAIT: samples occupied.
- If 0: move to PLACED.
- If 1: tries increments and the state returns to PICK.
REQ-025 When tries reaches MAX_TRIES (counting both range rejects and occupied rejects), SHALL move to SCAN_Q with the scan index at (col 0, row 0).
REQ-026 SCAN_Q/SCAN_W: queries cells in row-major order at 2 cycles per cell.
- A free cell moves to PLACED.
- After cell (GRID_COLS-1, GRID_ROWS-1) is found occupied, SHALL move to FULL.
REQ-027 On entering PLACED (registered, 1 cycle after the free sample), SHALL:
- set topLeft_x/topLeft_y from the cell using 32-bit zero-extended multiplication;
- set apple_valid=1;
- increment spawn_count.
REQ-028 PLACED: apple_eaten moves to PICK with tries=0; apple_valid=0 on the next cycle; topLeft holds its last value.
REQ-029 FULL: board_full=1 and apple_valid=0 until startGame.
REQ-030 apple_eaten outside PLACED SHALL be ignored.
REQ-031 startGame in any state SHALL:
- clear apple_valid, board_full, spawn_count and tries;
- enter PICK next cycle.
- startGame wins over a simultaneous apple_eaten.
REQ-032 query_valid SHALL be 0 in every state other than QUERY and SCAN_Q.

Reset
REQ-033 While resetN=0, SHALL force:
- state=IDLE, lfsr=LFSR_SEED;
- topLeft_x=0, topLeft_y=0;
- apple_valid=0, board_full=0, spawn_count=0, query_valid=0, query_col=0, query_row=0.
REQ-034 Reset asserted mid-search SHALL abort it with no placement; after release the block waits in IDLE for startGame.

Verification
REQ-035 occupied tied 0, startGame -> apple_valid=1 within 2*MAX_TRIES+4 cycles, topLeft_x%32=0, topLeft_x<=608, topLeft_y<=448, spawn_count=1.
REQ-036 occupied=1 except cell (3,2), after tries exhausted -> scan places the apple at topLeft=(96,64), apple_valid=1, board_full=0.
REQ-037 occupied tied 1, startGame -> exactly 300 scan queries, board_full=1, apple_valid=0; startGame then clears board_full.
REQ-038 In PLACED, apple_eaten -> apple_valid=0 next cycle, then re-placed with spawn_count=2; apple_eaten during PICK or WAIT has no effect.
REQ-039 startGame and apple_eaten in the same cycle -> spawn_count=0 and state PICK; resetN pulsed mid-WAIT -> all outputs at reset values, IDLE.
REQ-040 Checker on every query: query_col<20, query_row<15, and each query_valid pulse lasts 1 cycle.
